stdp_synapse: RTL and testbench

Parametrised plastic synapse sitting between a presynaptic and a postsynaptic LIF neuron in the spiking demo top level. Tracks cycles since each neuron's last spike, applies a pair-based STDP rule to a saturating weight register, and emits a weighted synaptic current pulse on every presynaptic spike. It generalises the fixed single-neuron path to configurable weight and timing widths, separate potentiation/depression rates, runtime learning enable and weight preload.

---
 rtl/stdp_synapse.sv | 141 ++++++++++++++
 tb/tb_stdp_synapse.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_synapse.sv
// stdp_synapse: pair-based STDP plastic synapse.
// Tracks cycles since the last pre/post spike, adjusts a saturating weight
// on lone spikes (post-after-pre potentiates, pre-after-post depresses), and
// emits the pre-update weight as a one-cycle current pulse on each pre spike.
module stdp_synapse #(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned T_WIDTH   = 4,
  parameter int unsigned W_INIT    = 64,
  parameter int unsigned LTP_SHIFT = 0,
  parameter int unsigned LTD_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
  input  logic               w_load,
  input  logic [W_WIDTH-1:0] w_load_val,
  output logic [W_WIDTH-1:0] weight,
  output logic [W_WIDTH-1:0] syn_out,
  output logic [T_WIDTH:0]   time_diff,
  output logic               update_flag,
  output logic               ltp
);

  // Saturated timer value doubles as "no recent spike".
  localparam logic [T_WIDTH-1:0] T_MAX   = {T_WIDTH{1'b1}};
  localparam logic [W_WIDTH-1:0] W_MAX   = {W_WIDTH{1'b1}};
  localparam logic [W_WIDTH-1:0] W_RESET = W_INIT[W_WIDTH-1:0];
  // Zero padding that widens a timer-sized dw to the W_WIDTH+1 arithmetic width.
  localparam int unsigned        PAD     = W_WIDTH + 1 - T_WIDTH;

  logic [T_WIDTH-1:0] pre_cnt;
  logic [T_WIDTH-1:0] post_cnt;
  logic [T_WIDTH-1:0] pre_cnt_nxt;
  logic [T_WIDTH-1:0] post_cnt_nxt;

  logic               ltp_evt;
  logic               ltd_evt;
  logic [T_WIDTH-1:0] ltp_mag;
  logic [T_WIDTH-1:0] ltd_mag;
  logic [T_WIDTH-1:0] ltp_dw;
  logic [T_WIDTH-1:0] ltd_dw;
  logic [W_WIDTH:0]   ltp_dw_ext;
  logic [W_WIDTH:0]   ltd_dw_ext;
  logic [W_WIDTH:0]   w_sum;
  logic [W_WIDTH:0]   w_diff;

  logic [W_WIDTH-1:0] weight_nxt;
  logic [T_WIDTH:0]   time_diff_nxt;
  logic               ltp_nxt;

  // Spike timers: a spike restarts at 0, otherwise count up and stick at T_MAX.
  always_comb begin
    pre_cnt_nxt  = pre_cnt;
    post_cnt_nxt = post_cnt;
    if (pre_spike) begin
      pre_cnt_nxt = '0;
    end else if (pre_cnt != T_MAX) begin
      pre_cnt_nxt = pre_cnt + 1'b1;
    end
    if (post_spike) begin
      post_cnt_nxt = '0;
    end else if (post_cnt != T_MAX) begin
      post_cnt_nxt = post_cnt + 1'b1;
    end
  end

  // Learning events and step sizes; simultaneous spikes and preloads suppress learning.
  always_comb begin
    ltp_evt    = learn_en & ~w_load & post_spike & ~pre_spike;
    ltd_evt    = learn_en & ~w_load & pre_spike & ~post_spike;
    ltp_mag    = T_MAX - pre_cnt;
    ltd_mag    = T_MAX - post_cnt;
    ltp_dw     = ltp_mag >> LTP_SHIFT;
    ltd_dw     = ltd_mag >> LTD_SHIFT;
    ltp_dw_ext = {{PAD{1'b0}}, ltp_dw};
    ltd_dw_ext = {{PAD{1'b0}}, ltd_dw};
    // One extra bit catches overflow (sum) and borrow (diff) for clamping.
    w_sum      = {1'b0, weight} + ltp_dw_ext;
    w_diff     = {1'b0, weight} - ltd_dw_ext;
  end

  // Next weight / timing-difference / polarity, with preload taking priority.
  always_comb begin
    weight_nxt    = weight;
    time_diff_nxt = time_diff;
    ltp_nxt       = ltp;
    if (w_load) begin
      weight_nxt = w_load_val;
    end else if (ltp_evt) begin
      weight_nxt    = w_sum[W_WIDTH] ? W_MAX : w_sum[W_WIDTH-1:0];
      time_diff_nxt = {1'b0, pre_cnt};
      ltp_nxt       = 1'b1;
    end else if (ltd_evt) begin
      weight_nxt    = w_diff[W_WIDTH] ? '0 : w_diff[W_WIDTH-1:0];
      time_diff_nxt = '0 - {1'b0, post_cnt};
      ltp_nxt       = 1'b0;
    end
  end

  // Timer registers; frozen while the synapse is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= T_MAX;
      post_cnt <= T_MAX;
    end else if (ena) begin
      pre_cnt  <= pre_cnt_nxt;
      post_cnt <= post_cnt_nxt;
    end
  end

  // Plastic state: weight plus the record of the last learning evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight    <= W_RESET;
      time_diff <= '0;
      ltp       <= 1'b0;
    end else if (ena) begin
      weight    <= weight_nxt;
      time_diff <= time_diff_nxt;
      ltp       <= ltp_nxt;
    end
  end

  // Pulse outputs: current carries the pre-update weight; both drop to 0 when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_out     <= '0;
      update_flag <= 1'b0;
    end else if (ena) begin
      syn_out     <= pre_spike ? weight : '0;
      update_flag <= ltp_evt | ltd_evt;
    end else begin
      syn_out     <= '0;
      update_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Bench for stdp_synapse: a behavioural model predicts outputs per edge,
// pushes them to a queue at drive time, and each test pops and compares.
module tb_stdp_synapse;

  localparam int TMAX   = 15;
  localparam int WMAXV  = 255;
  localparam int LTP_SH = 0;
  localparam int LTD_SH = 1;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic       w_load;
  logic [7:0] w_load_val;
  logic [7:0] weight;
  logic [7:0] syn_out;
  logic [4:0] time_diff;
  logic       update_flag;
  logic       ltp;

  stdp_synapse dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pre_spike(pre_spike),
    .post_spike(post_spike), .learn_en(learn_en), .w_load(w_load),
    .w_load_val(w_load_val), .weight(weight), .syn_out(syn_out),
    .time_diff(time_diff), .update_flag(update_flag), .ltp(ltp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int         m_w;
  int         m_pre;
  int         m_post;
  logic [4:0] m_td;
  logic       m_ltp;

  // expected {weight, syn_out, time_diff, update_flag, ltp}
  logic [22:0] exp_q[$];

  // stimulus word {ena, pre, post, learn, wload, val[7:0]}
  function automatic logic [12:0] sv(input bit e, input bit p, input bit q,
                                     input bit l, input bit wl, input logic [7:0] v);
    return {e, p, q, l, wl, v};
  endfunction

  task automatic model_reset();
    m_w = 64; m_pre = TMAX; m_post = TMAX; m_td = '0; m_ltp = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic [12:0] s);
    bit e, p, q, l, wl;
    logic [7:0] v;
    logic [7:0] syn;
    logic [4:0] tmp;
    logic f;
    int dw;
    {e, p, q, l, wl, v} = s;
    ena = e; pre_spike = p; post_spike = q; learn_en = l; w_load = wl; w_load_val = v;
    syn = '0; f = 1'b0;
    if (e) begin
      if (p) syn = m_w[7:0];
      if (wl) begin
        m_w = int'(v);
      end else if (l && q && !p) begin
        dw = (TMAX - m_pre) >> LTP_SH;
        m_w = (m_w + dw > WMAXV) ? WMAXV : m_w + dw;
        m_td = 5'(m_pre); m_ltp = 1'b1; f = 1'b1;
      end else if (l && p && !q) begin
        dw = (TMAX - m_post) >> LTD_SH;
        m_w = (m_w - dw < 0) ? 0 : m_w - dw;
        tmp = 5'(m_post); m_td = -tmp; m_ltp = 1'b0; f = 1'b1;
      end
      m_pre  = p ? 0 : ((m_pre  < TMAX) ? m_pre  + 1 : TMAX);
      m_post = q ? 0 : ((m_post < TMAX) ? m_post + 1 : TMAX);
    end
    exp_q.push_back({m_w[7:0], syn, m_td, f, m_ltp});
    @(posedge clk);
    @(negedge clk);
  endtask

  // load a weight, then idle long enough for both timers to go stale
  task automatic prep(inout logic [12:0] sq[$], input logic [7:0] val);
    sq.push_back(sv(1, 0, 0, 1, 1, val));
    for (int i = 0; i < 16; i++) sq.push_back(sv(1, 0, 0, 1, 0, 8'd0));
  endtask

  task automatic test_reset();
    logic [22:0] got, exp;
    rst_n = 1'b0; ena = 0; pre_spike = 0; post_spike = 0; learn_en = 0;
    w_load = 0; w_load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== {8'd64, 8'd0, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_hold: got %h expected %h", got, {8'd64, 8'd0, 5'd0, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== {8'd64, 8'd0, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_release: got %h expected %h", got, {8'd64, 8'd0, 5'd0, 1'b0, 1'b0});
    end
    // lone pre right after reset exposes post_cnt = 15 as time_diff = -15, dw = 0
    step(sv(1, 1, 0, 1, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_first_pre: got %h expected %h", got, exp);
    end
    n_cmp++;
    if (time_diff !== 5'b10001 || weight !== 8'd64 || syn_out !== 8'd64) begin
      n_err++; $display("FAIL reset_timer_stale: got td=%b w=%0d syn=%0d required td=10001 w=64 syn=64",
                        time_diff, weight, syn_out);
    end
  endtask

  task automatic test_ltp();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd64);
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ltp_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (weight !== 8'd77 || time_diff !== 5'd2 || ltp !== 1'b1 || update_flag !== 1'b1) begin
      n_err++; $display("FAIL ltp_result: got w=%0d td=%0d ltp=%b flag=%b required w=77 td=2 ltp=1 flag=1",
                        weight, time_diff, ltp, update_flag);
    end
    step(sv(1, 0, 0, 1, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || update_flag !== 1'b0) begin
      n_err++; $display("FAIL ltp_flag_one_cycle: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_ltd();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd64);
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    for (int i = 0; i < 3; i++) sq.push_back(sv(1, 0, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ltd_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (weight !== 8'd58 || time_diff !== 5'b11101 || ltp !== 1'b0 || syn_out !== 8'd64 || update_flag !== 1'b1) begin
      n_err++; $display("FAIL ltd_result: got w=%0d td=%b ltp=%b syn=%0d flag=%b required w=58 td=11101 ltp=0 syn=64 flag=1",
                        weight, time_diff, ltp, syn_out, update_flag);
    end
  endtask

  task automatic test_saturation();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd250);
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL sat_hi_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (weight !== 8'd255) begin
      n_err++; $display("FAIL sat_high: got w=%0d required 255", weight);
    end
    sq.delete();
    prep(sq, 8'd2);
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL sat_lo_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (weight !== 8'd0) begin
      n_err++; $display("FAIL sat_low: got w=%0d required 0", weight);
    end
  endtask

  task automatic test_simul_nolearn();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd100);
    sq.push_back(sv(1, 1, 1, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL simul_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (weight !== 8'd100 || update_flag !== 1'b0 || syn_out !== 8'd100) begin
      n_err++; $display("FAIL simul_spikes: got w=%0d flag=%b syn=%0d required w=100 flag=0 syn=100",
                        weight, update_flag, syn_out);
    end
    // LTP-shaped pair with learning off: weight holds, syn_out still pulses
    step(sv(1, 1, 0, 0, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || syn_out !== 8'd100 || update_flag !== 1'b0) begin
      n_err++; $display("FAIL nolearn_pre: got %h expected %h", got, exp);
    end
    step(sv(1, 0, 1, 0, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || weight !== 8'd100 || update_flag !== 1'b0) begin
      n_err++; $display("FAIL nolearn_post: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_ena_hold();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd100);
    sq.push_back(sv(0, 1, 0, 1, 0, 8'd0));
    sq.push_back(sv(0, 0, 0, 1, 1, 8'd5));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ena_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
    // the ignored pre spike leaves pre_cnt stale, so the post sees +15 and dw = 0
    n_cmp++;
    if (weight !== 8'd100 || time_diff !== 5'd15 || ltp !== 1'b1) begin
      n_err++; $display("FAIL ena_ignored: got w=%0d td=%0d ltp=%b required w=100 td=15 ltp=1",
                        weight, time_diff, ltp);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] sq[$];
    logic [22:0] got, exp;
    prep(sq, 8'd128);
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    sq.push_back(sv(1, 0, 1, 1, 0, 8'd0));
    sq.push_back(sv(1, 1, 0, 1, 0, 8'd0));
    for (int i = 0; i < 300; i++) begin
      sq.push_back(sv(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                      ($urandom % 6) != 0, ($urandom % 20) == 0, 8'($urandom)));
    end
    foreach (sq[i]) begin
      step(sq[i]);
      exp = exp_q.pop_front();
      got = {weight, syn_out, time_diff, update_flag, ltp};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL b2b_seq[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [22:0] got, exp;
    step(sv(1, 0, 0, 1, 1, 8'd100));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || weight !== 8'd100) begin
      n_err++; $display("FAIL arst_load: got %h expected %h", got, exp);
    end
    step(sv(1, 1, 0, 0, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || syn_out !== 8'd100) begin
      n_err++; $display("FAIL arst_pulse: got %h expected %h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== {8'd64, 8'd0, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL arst_immediate: got %h expected %h", got, {8'd64, 8'd0, 5'd0, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(sv(1, 0, 1, 1, 0, 8'd0));
    exp = exp_q.pop_front();
    got = {weight, syn_out, time_diff, update_flag, ltp};
    n_cmp++;
    if (got !== exp || time_diff !== 5'd15) begin
      n_err++; $display("FAIL arst_recover: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_ltp();
    test_ltd();
    test_saturation();
    test_simul_nolearn();
    test_ena_hold();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
